y86_fetch_seq: RTL and testbench
================================

# y86_fetch_seq

Multi-cycle fetch sequencer for the SEQ Y86-64 core. It reads one instruction from a byte-wide instruction memory over a req/ack handshake, a byte per transfer. Instruction length is decided from the first byte, and the sequencer stops after the last byte needed. It then presents decoded icode/ifun/rA/rB/valC/valP with a validity flag and a memory-error flag, so the combinational decode can be replaced by a real memory port.

## Interface
- IMEM_BYTES, 1024: instruction memory size in bytes; addresses >= IMEM_BYTES are out of range.
- Clk  in  1  clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  request fetch at pc_in; sampled only in IDLE.
- pc_in  in  64  address of instruction byte 0.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; result outputs updated on the same edge.
- mem_req  out  1  byte read request.
- mem_addr  out  64  byte address; stable while mem_req high and not acked.
- mem_ack  in  1  transfer completes in any cycle mem_req & mem_ack.
- mem_rdata  in  8  byte data, valid in the ack cycle.
- icode, ifun, rA, rB  out  4 each  decoded fields.
- valC  out  64  constant word, little-endian assembled.
- valP  out  64  pc_in + consumed length, modulo 2^64.
- instr_valid  out  1  icode/ifun legal and all bytes fetched.
- mem_error  out  1  a required byte address was out of range.

## Operation
- States: IDLE, FETCH, DONE.
- IDLE: start=1 latches pc_in, sets byte index k=0 and goes to FETCH. start is ignored in any other state.
- FETCH:
  - Before issuing byte k, compute pc+k in 65 bits. If it is >= IMEM_BYTES, do not issue; go to DONE with mem_error=1 and instr_valid=0.
  - Otherwise drive mem_req=1 and mem_addr=pc+k. On ack, store the byte and set k=k+1.
- Byte 0 sets icode=byte[7:4], ifun=byte[3:0], and fixes the length L:
  - icode 0, 1, 9: L=1. ifun must be 0.
  - icode 2, 6: L=2. ifun must be 0..5.
  - icode A, B: L=2. ifun must be 0.
  - icode 3, 4, 5: L=10. ifun must be 0.
  - icode 7: L=9. ifun must be 0..6.
  - icode 8: L=9. ifun must be 0.
  - icode C..F, or an illegal ifun: L=1, instr_valid=0, go to DONE.
- Register byte (icode 2, 3, 4, 5, 6, A, B): byte 1 gives rA=[7:4], rB=[3:0].
- valC placement:
  - icode 3, 4, 5: valC = bytes 2..9, byte 2 least significant.
  - icode 7, 8: valC = bytes 1..8, byte 1 least significant.
- Fields not carried by an instruction: rA=rB=0xF, valC=0.
- When k==L, go to DONE.
- DONE: for one cycle, done=1 and busy=0, outputs are registered and valP=pc+k. Then return to IDLE. A start in the DONE cycle is ignored.
- On memory error: valP=pc+k, where k is the bytes actually fetched. Already-decoded fields are kept; undecoded fields take their defaults.
- Result outputs hold until the next done.
- Reset values:
  - busy, done, mem_req, instr_valid, mem_error = 0.
  - icode, ifun = 0; rA, rB = 0xF.
  - valC, valP, mem_addr = 0.
  - State = IDLE.
- Reset in FETCH: the transfer is abandoned, mem_req is 0 after the edge, and no done is produced. An ack arriving after reset is ignored.

## Timing
- Cycle 0: start accepted. Cycle 1: busy=1, mem_req=1, mem_addr=pc.
- With zero-wait memory (ack in the same cycle as req), byte k is requested in cycle 1+k. mem_req stays high across back-to-back bytes and mem_addr advances on the edge after each ack.
- done is asserted at cycle 1+N, where N is the total number of cycles of mem_req needed for L acks. Minimum latency from start is L+1 cycles.
- A range error detected before byte k is issued: done occurs at cycle 1+(cycles spent so far). An error at byte 0 gives done at cycle 1 with mem_req never raised.
- Wait states: mem_req and mem_addr are held unchanged, with no timeout.
- At most one byte is accepted per cycle.

## Test plan
- halt: mem[0]=0x00, start pc=0, zero-wait → done at cycle 2; icode=0, valP=1, instr_valid=1, rA=rB=0xF, valC=0.
- irmovq: mem[0x10..0x19] = 30 F3 EF CD AB 89 67 45 23 01 → rA=0xF, rB=3, valC=0x0123456789ABCDEF, valP=0x1A, done at cycle 11.
- jXX with random ack stalls (0–3 cycles): mem[0]=0x73, valC bytes 00..07 → ifun=3, valC=0x0706050403020100, valP=9, mem_addr stable during every stall.
- Invalid instructions:
  - mem[0]=0xC0 → one byte read, instr_valid=0, valP=1.
  - mem[0]=0x27 → instr_valid=0.
- Range errors with IMEM_BYTES=1024:
  - pc=1020 with a 10-byte instruction → 4 acks, mem_error=1, valP=1024, no request to address 1024.
  - pc=0xFFFFFFFFFFFFFFFF → mem_error=1 at cycle 1, mem_req never raised.
- Reset in FETCH after 3 acks → mem_req=0, busy=0 and no done. Then start pc=0 (mem[0]=0x10) → normal nop result with valP=1. start while busy is ignored.

Source files
------------

// File: rtl/y86_fetch_seq.sv
// Multi-cycle byte-serial instruction fetch for the SEQ Y86-64 core.
// Reads one instruction a byte at a time and presents the decoded fields on a one-cycle done pulse.
module y86_fetch_seq #(
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [63:0] i_pc_in,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_mem_req,
    output logic [63:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [7:0]  i_mem_rdata,
    output logic [3:0]  o_icode,
    output logic [3:0]  o_ifun,
    output logic [3:0]  o_ra,
    output logic [3:0]  o_rb,
    output logic [63:0] o_valc,
    output logic [63:0] o_valp,
    output logic        o_instr_valid,
    output logic        o_mem_error,
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [64:0] LIMIT = 65'(IMEM_BYTES);

    state_t r_state;
    state_t w_state_next;

    logic [63:0] r_pc;
    logic [3:0]  r_k;
    logic [3:0]  r_len;
    logic [63:0] r_mem_addr;

    // Fields accumulated while bytes arrive; copied to the result registers on entry to DONE.
    logic [3:0]  r_acc_icode;
    logic [3:0]  r_acc_ifun;
    logic [3:0]  r_acc_ra;
    logic [3:0]  r_acc_rb;
    logic [63:0] r_acc_valc;

    logic [3:0]  r_icode;
    logic [3:0]  r_ifun;
    logic [3:0]  r_ra;
    logic [3:0]  r_rb;
    logic [63:0] r_valc;
    logic [63:0] r_valp;
    logic        r_instr_valid;
    logic        r_mem_error;

    logic        w_ack;
    logic        w_first;
    logic [3:0]  w_dec_len;
    logic        w_dec_legal;
    logic        w_illegal;
    logic [3:0]  w_len_eff;
    logic [3:0]  w_next_k;
    logic        w_last;
    logic [64:0] w_next_addr;
    logic        w_next_oor;
    logic        w_start_oor;
    logic        w_fetch_end;
    logic        w_has_regs;
    logic [3:0]  w_valc_off;
    logic [2:0]  w_valc_idx;
    logic        w_valc_hit;
    logic [3:0]  w_upd_icode;
    logic [3:0]  w_upd_ifun;
    logic [3:0]  w_upd_ra;
    logic [3:0]  w_upd_rb;
    logic [63:0] w_upd_valc;

    // Handshake: a byte moves in any cycle with mem_req && mem_ack; until then
    // mem_req stays high and mem_addr is held. mem_req is high exactly in FETCH.
    assign o_mem_req  = (r_state == S_FETCH);
    assign o_busy     = (r_state == S_FETCH);
    assign o_done     = (r_state == S_DONE);
    assign o_mem_addr = r_mem_addr;
    assign o_state    = r_state;

    assign o_icode       = r_icode;
    assign o_ifun        = r_ifun;
    assign o_ra          = r_ra;
    assign o_rb          = r_rb;
    assign o_valc        = r_valc;
    assign o_valp        = r_valp;
    assign o_instr_valid = r_instr_valid;
    assign o_mem_error   = r_mem_error;

    assign w_ack       = (r_state == S_FETCH) && i_mem_ack;
    assign w_first     = (r_k == 4'd0);
    assign w_next_k    = r_k + 4'd1;
    assign w_next_addr = {1'b0, r_pc} + {61'b0, w_next_k};
    assign w_next_oor  = (w_next_addr >= LIMIT);
    assign w_start_oor = ({1'b0, i_pc_in} >= LIMIT);

    always_comb begin
        w_dec_len   = 4'd1;
        w_dec_legal = 1'b0;
        case (i_mem_rdata[7:4])
            4'h0, 4'h1, 4'h9: begin
                w_dec_len   = 4'd1;
                w_dec_legal = (i_mem_rdata[3:0] == 4'd0);
            end
            4'h2, 4'h6: begin
                w_dec_len   = 4'd2;
                w_dec_legal = (i_mem_rdata[3:0] <= 4'd5);
            end
            4'hA, 4'hB: begin
                w_dec_len   = 4'd2;
                w_dec_legal = (i_mem_rdata[3:0] == 4'd0);
            end
            4'h3, 4'h4, 4'h5: begin
                w_dec_len   = 4'd10;
                w_dec_legal = (i_mem_rdata[3:0] == 4'd0);
            end
            4'h7: begin
                w_dec_len   = 4'd9;
                w_dec_legal = (i_mem_rdata[3:0] <= 4'd6);
            end
            4'h8: begin
                w_dec_len   = 4'd9;
                w_dec_legal = (i_mem_rdata[3:0] == 4'd0);
            end
            default: begin
                w_dec_len   = 4'd1;
                w_dec_legal = 1'b0;
            end
        endcase
    end

    assign w_illegal   = w_first && !w_dec_legal;
    assign w_len_eff   = w_first ? w_dec_len : r_len;
    assign w_last      = w_illegal || (w_next_k == w_len_eff);
    assign w_fetch_end = w_ack && (w_last || w_next_oor);

    always_comb begin
        w_has_regs = 1'b0;
        w_valc_off = 4'd0;
        case (r_acc_icode)
            4'h2, 4'h6, 4'hA, 4'hB: w_has_regs = 1'b1;
            4'h3, 4'h4, 4'h5: begin
                w_has_regs = 1'b1;
                w_valc_off = 4'd2;
            end
            4'h7, 4'h8: w_valc_off = 4'd1;
            default: begin
                w_has_regs = 1'b0;
                w_valc_off = 4'd0;
            end
        endcase
    end

    // valC bytes arrive in ascending significance, so each lands in a fresh byte lane.
    assign w_valc_idx = 3'(r_k - w_valc_off);
    assign w_valc_hit = !w_first && (w_valc_off != 4'd0) && (r_k >= w_valc_off);

    assign w_upd_icode = w_first ? i_mem_rdata[7:4] : r_acc_icode;
    assign w_upd_ifun  = w_first ? i_mem_rdata[3:0] : r_acc_ifun;
    assign w_upd_ra    = (r_k == 4'd1 && w_has_regs) ? i_mem_rdata[7:4] : r_acc_ra;
    assign w_upd_rb    = (r_k == 4'd1 && w_has_regs) ? i_mem_rdata[3:0] : r_acc_rb;
    assign w_upd_valc  = w_valc_hit
                       ? (r_acc_valc | (64'(i_mem_rdata) << {w_valc_idx, 3'b000}))
                       : r_acc_valc;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_next = w_start_oor ? S_DONE : S_FETCH;
            S_FETCH: if (w_fetch_end) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc          <= '0;
            r_k           <= '0;
            r_len         <= 4'd1;
            r_mem_addr    <= '0;
            r_acc_icode   <= '0;
            r_acc_ifun    <= '0;
            r_acc_ra      <= 4'hF;
            r_acc_rb      <= 4'hF;
            r_acc_valc    <= '0;
            r_icode       <= '0;
            r_ifun        <= '0;
            r_ra          <= 4'hF;
            r_rb          <= 4'hF;
            r_valc        <= '0;
            r_valp        <= '0;
            r_instr_valid <= 1'b0;
            r_mem_error   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_pc        <= i_pc_in;
                        r_k         <= '0;
                        r_len       <= 4'd1;
                        r_mem_addr  <= i_pc_in;
                        r_acc_icode <= '0;
                        r_acc_ifun  <= '0;
                        r_acc_ra    <= 4'hF;
                        r_acc_rb    <= 4'hF;
                        r_acc_valc  <= '0;
                        if (w_start_oor) begin
                            r_icode       <= '0;
                            r_ifun        <= '0;
                            r_ra          <= 4'hF;
                            r_rb          <= 4'hF;
                            r_valc        <= '0;
                            r_valp        <= i_pc_in;
                            r_instr_valid <= 1'b0;
                            r_mem_error   <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (w_ack) begin
                        r_k         <= w_next_k;
                        r_mem_addr  <= w_next_addr[63:0];
                        r_acc_icode <= w_upd_icode;
                        r_acc_ifun  <= w_upd_ifun;
                        r_acc_ra    <= w_upd_ra;
                        r_acc_rb    <= w_upd_rb;
                        r_acc_valc  <= w_upd_valc;
                        if (w_first) r_len <= w_dec_len;
                    end
                    if (w_fetch_end) begin
                        r_icode       <= w_upd_icode;
                        r_ifun        <= w_upd_ifun;
                        r_ra          <= w_upd_ra;
                        r_rb          <= w_upd_rb;
                        r_valc        <= w_upd_valc;
                        r_valp        <= w_next_addr[63:0];
                        r_instr_valid <= w_last && !w_illegal;
                        r_mem_error   <= !w_last && w_next_oor;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_y86_fetch_seq.sv
// Bench for y86_fetch_seq: byte memory with random ack stalls, checked against
// an instruction-level reference model of the fetch rules.
module tb_y86_fetch_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] pc_in;
    logic        busy, done, mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic        instr_valid, mem_error;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    y86_fetch_seq #(.IMEM_BYTES(1024)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_pc_in(pc_in),
        .o_busy(busy), .o_done(done), .o_mem_req(mem_req), .o_mem_addr(mem_addr),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
        .o_icode(icode), .o_ifun(ifun), .o_ra(ra), .o_rb(rb),
        .o_valc(valc), .o_valp(valp), .o_instr_valid(instr_valid),
        .o_mem_error(mem_error), .o_state(dbg_state)
    );

    logic [7:0] mem [0:1023];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic        valid, err;
        int          nbytes;
    } res_t;

    // Instruction length and highest legal ifun per icode (-1: no legal ifun).
    int len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
    int max_ifun[16] = '{0, 0, 5, 0, 0, 0, 5, 6, 0, 0, 0, 0, -1, -1, -1, -1};

    function automatic res_t model(input logic [63:0] pc);
        res_t r;
        logic [63:0] a;
        logic [7:0]  b;
        int len;
        r.icode = 0; r.ifun = 0; r.ra = 4'hF; r.rb = 4'hF; r.valc = 0;
        r.valid = 0; r.err = 0; r.nbytes = 0; r.valp = pc;
        if (pc >= 64'd1024) begin
            r.err = 1;
            return r;
        end
        b = mem[pc[9:0]];
        r.icode = b[7:4]; r.ifun = b[3:0]; r.nbytes = 1;
        if (int'(r.ifun) > max_ifun[r.icode]) begin
            r.valp = pc + 64'd1;
            return r;
        end
        len = len_tab[r.icode];
        for (int j = 1; j < len; j++) begin
            a = pc + 64'(j);
            if (a >= 64'd1024) begin
                r.err = 1;
                break;
            end
            b = mem[a[9:0]];
            if (j == 1 && r.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
                r.ra = b[7:4]; r.rb = b[3:0];
            end
            if (r.icode inside {4'h3, 4'h4, 4'h5}) begin
                if (j >= 2) r.valc[8*(j-2) +: 8] = b;
            end else if (r.icode inside {4'h7, 4'h8}) begin
                r.valc[8*(j-1) +: 8] = b;
            end
            r.nbytes = j + 1;
        end
        r.valp = pc + 64'(r.nbytes);
        r.valid = !r.err;
        return r;
    endfunction

    // One complete fetch: start, serve bytes with random stalls, check result and timing.
    task automatic run_fetch(input string name, input logic [63:0] pc, input int max_stall);
        res_t e;
        int cyc, req_cycles, acks, stall_left;
        bit pending, seen_done;
        e = model(pc);
        @(negedge clk);
        start = 1'b1;
        pc_in = pc;
        cyc = 0; req_cycles = 0; acks = 0; stall_left = 0; pending = 0; seen_done = 0;
        while (!seen_done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            mem_ack = 1'b0;
            if (done) begin
                seen_done = 1;
                check_val({name, ":icode"}, icode, e.icode);
                check_val({name, ":ifun"}, ifun, e.ifun);
                check_val({name, ":ra"}, ra, e.ra);
                check_val({name, ":rb"}, rb, e.rb);
                check_val({name, ":valc"}, valc, e.valc);
                check_val({name, ":valp"}, valp, e.valp);
                check_val({name, ":valid"}, instr_valid, e.valid);
                check_val({name, ":mem_error"}, mem_error, e.err);
                check_val({name, ":acks"}, acks, e.nbytes);
                check_val({name, ":done_cycle"}, cyc, 1 + req_cycles);
                if (max_stall == 0) check_val({name, ":latency"}, cyc, 1 + e.nbytes);
                check_val({name, ":busy_at_done"}, busy, 0);
            end else begin
                check_val({name, ":busy"}, busy, 1);
                if (mem_req) begin
                    check_val({name, ":addr"}, mem_addr, pc + 64'(acks));
                    check_val({name, ":addr_range"}, mem_addr < 64'd1024, 1);
                    if (!pending) stall_left = $urandom_range(0, max_stall);
                    req_cycles++;
                    if (stall_left > 0) begin
                        stall_left--;
                        pending = 1;
                    end else begin
                        mem_ack = 1'b1;
                        mem_rdata = mem[mem_addr[9:0]];
                        acks++;
                        pending = 0;
                    end
                end
            end
            start = 1'($urandom_range(0, 1));
            pc_in = 64'($urandom_range(0, 1023));
        end
        if (!seen_done) check_val({name, ":timeout"}, 0, 1);
        @(negedge clk);
        check_val({name, ":idle_done"}, done, 0);
        check_val({name, ":idle_busy"}, busy, 0);
        check_val({name, ":hold_valp"}, valp, e.valp);
        start = 1'b0;
        mem_ack = 1'b0;
    endtask

    initial begin
        logic [7:0]  irm [10];
        logic [63:0] rpc;
        int acks, cyc;
        irm = '{8'h30, 8'hF3, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        reset = 1'b1; start = 1'b0; pc_in = '0; mem_ack = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);

        repeat (2) @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_req", mem_req, 0);
        check_val("rst_valid", instr_valid, 0);
        check_val("rst_err", mem_error, 0);
        check_val("rst_icode", {icode, ifun}, 8'h00);
        check_val("rst_rarb", {ra, rb}, 8'hFF);
        check_val("rst_valc", valc, 0);
        check_val("rst_valp", valp, 0);
        check_val("rst_addr", mem_addr, 0);
        reset = 1'b0;

        mem[0] = 8'h00;
        run_fetch("halt", 64'd0, 0);
        check_val("halt_valp_lit", valp, 64'd1);

        for (int i = 0; i < 10; i++) mem[16 + i] = irm[i];
        run_fetch("irmovq", 64'h10, 0);
        check_val("irmovq_valc_lit", valc, 64'h0123456789ABCDEF);
        check_val("irmovq_valp_lit", valp, 64'h1A);

        mem[0] = 8'h73;
        for (int i = 0; i < 8; i++) mem[1 + i] = 8'(i);
        run_fetch("jxx_stall", 64'd0, 3);
        check_val("jxx_valc_lit", valc, 64'h0706050403020100);

        mem[0] = 8'hC0;
        run_fetch("inv_c0", 64'd0, 1);
        mem[0] = 8'h27;
        run_fetch("inv_27", 64'd0, 0);

        mem[1020] = 8'h30;
        run_fetch("range_1020", 64'd1020, 1);
        check_val("range_valp_lit", valp, 64'd1024);
        run_fetch("range_top", 64'hFFFF_FFFF_FFFF_FFFF, 0);

        // Reset in the middle of a 10-byte fetch, with ack still asserted afterwards.
        mem[0] = 8'h30;
        @(negedge clk);
        start = 1'b1; pc_in = 64'd0;
        @(negedge clk);
        start = 1'b0;
        acks = 0; cyc = 0;
        while (acks < 3 && cyc < 20) begin
            mem_ack = mem_req;
            if (mem_req) begin
                mem_rdata = mem[mem_addr[9:0]];
                acks++;
            end
            cyc++;
            @(negedge clk);
        end
        check_val("mid_acks", acks, 3);
        reset = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        check_val("mid_rst_req", mem_req, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_done", done, 0);
        check_val("mid_rst_rb", rb, 4'hF);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_val("post_rst_done", done, 0);
            check_val("post_rst_req", mem_req, 0);
        end
        mem_ack = 1'b0;
        mem[0] = 8'h10;
        run_fetch("nop_after_rst", 64'd0, 0);
        check_val("nop_valp_lit", valp, 64'd1);

        repeat (40) begin
            case ($urandom_range(0, 3))
                0:       rpc = {$urandom, $urandom};
                1:       rpc = 64'($urandom_range(1012, 1023));
                default: rpc = 64'($urandom_range(0, 1000));
            endcase
            if (rpc < 64'd1024)
                mem[rpc[9:0]] = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 7))};
            run_fetch("rand", rpc, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
